gfx_fader: RTL
==============

// Module: gfx_fader
//
// PURPOSE
// - Frame-buffer fade/blank engine: AXI master on the third (fade) port of
//   the 3-to-2 SRAM arbiter, beside the gfx writer and display reader.
// - Each start pulse runs one pass over the frame buffer: read pixel,
//   decrement its meta intensity, write it back; zero intensity -> colour
//   blanked. Emulates vector-display phosphor decay.
//
// PARAMETERS
// - PIXEL_BITS      12      colour bits per pixel (r,g,b packed)
// - META_BITS       4       intensity bits, stored below colour
// - AXI_ADDR_WIDTH  20      SRAM word address width
// - AXI_DATA_WIDTH  16      SRAM word width; >= PIXEL_BITS+META_BITS
// - FB_PIXELS       307200  pixels per pass; addresses 0..FB_PIXELS-1
// - FADE_STEP       1       intensity decrement per pass; 1..2^META_BITS-1
//
// PORTS
// - axi_clk       in   1    clock
// - axi_resetn    in   1    async active-low reset
// - start         in   1    one-cycle pulse: begin a pass (driven from vsync)
// - enable        in   1    0 = pause at next pixel boundary
// - busy          out  1    pass in progress
// - done          out  1    one-cycle pulse after last write response
// - axi_araddr    out  AW   read address
// - axi_arvalid   out  1
// - axi_arready   in   1
// - axi_rdata     in   DW   read data
// - axi_rresp     in   2    ignored
// - axi_rvalid    in   1
// - axi_rready    out  1
// - axi_awaddr    out  AW   write address (= read address of same pixel)
// - axi_awvalid   out  1
// - axi_awready   in   1
// - axi_wdata     out  DW   faded pixel
// - axi_wstrb     out  DW/8 always all ones
// - axi_wvalid    out  1
// - axi_wready    in   1
// - axi_bresp     in   2    ignored
// - axi_bvalid    in   1
// - axi_bready    out  1
//
// BEHAVIOUR
// - One clock, axi_clk; reset async active-low (axi_resetn).
// - Reset: state IDLE, addr 0; busy, done, all valid/ready outputs 0.
// - FSM: IDLE -> start -> AR -> arready -> R -> rvalid -> AW_W -> aw and w
//   both done -> B -> bvalid -> NEXT.
// - NEXT: addr==FB_PIXELS-1 -> IDLE, done=1 for 1 cycle, addr=0;
//   else addr+1 -> AR if enable, else hold in NEXT.
// - One pixel in flight; no overlap of read and write.
// - AR: arvalid=1, araddr=addr; held stable until arready.
// - R: rready=1; rdata captured on rvalid&rready.
// - AW_W: awvalid and wvalid raised together; each drops on its own handshake.
// - B: bready=1 until bvalid.
// - Pixel layout: rdata[PIXEL_BITS+META_BITS-1:0] = {colour, meta}.
// - Fade: new_meta = meta > FADE_STEP ? meta-FADE_STEP : 0.
//   new_colour = new_meta==0 ? 0 : colour.
//   wdata = {zero pad, new_colour, new_meta}.
// - busy=1 from the cycle after start until the cycle done pulses.
// - start while busy: ignored (no queued pass).
// - enable low mid-pixel: current pixel completes; pause only in NEXT.
// - enable low in IDLE: start still accepted; pass waits in AR until
//   enable=1.
// - start and enable=0 on the same cycle: pass starts, AR waits.
// - Reset mid-pass: abort immediately; outstanding AXI transaction dropped.
//   The arbiter is reset by the same signal.
//
// CONFIGURATION
// - GFX_FADER_SKIP_EN defined: a pixel read as all zero
//   (colour==0, meta==0) skips AW_W/B and goes R -> NEXT.
//   Saves SRAM bandwidth on blank areas.
// - Undefined: every pixel is written back, including all-zero pixels.
//
// TESTING
// - FB_PIXELS=4, pixels {0xABC,4}, {0x123,1}, {0xFFF,0}, {0,0}; start ->
//   writes {0xABC,3}, {0x000,0}, {0x000,0}, {0,0}; done after 4th bresp.
// - FADE_STEP=3, pixel {0x555,2} -> written {0x000,0} (saturate to 0).
// - arready/awready/wready/bvalid randomly stalled 0-5 cycles ->
//   addr/data stable while valid is high; results same as unstalled run.
// - awready one cycle before wready, then reversed ->
//   exactly one AW and one W handshake per pixel.
// - enable=0 after pixel 1 for 10 cycles -> no arvalid in that window;
//   resume at addr 2. start pulsed mid-pass -> ignored, a single done.
// - GFX_FADER_SKIP_EN with an all-zero pixel at addr 3 -> no awvalid for
//   addr 3; without the macro -> a zero write to addr 3.
//   axi_resetn pulsed mid-pass -> all outputs 0, busy=0, next pass from 0.

Source files
------------

// File: rtl/gfx_fader_if.sv
// AXI master/slave bundle between the fade engine and the SRAM arbiter port.
// Carries the five AXI channels; rresp/bresp are present but not interpreted.
// Parameterised by address width AW and data width DW.
interface gfx_fader_if #(
  parameter int AW = 20,
  parameter int DW = 16
);
  logic [AW-1:0]   axi_araddr;
  logic            axi_arvalid;
  logic            axi_arready;
  logic [DW-1:0]   axi_rdata;
  logic [1:0]      axi_rresp;
  logic            axi_rvalid;
  logic            axi_rready;
  logic [AW-1:0]   axi_awaddr;
  logic            axi_awvalid;
  logic            axi_awready;
  logic [DW-1:0]   axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic            axi_wvalid;
  logic            axi_wready;
  logic [1:0]      axi_bresp;
  logic            axi_bvalid;
  logic            axi_bready;

  modport master (
    output axi_araddr, axi_arvalid, input axi_arready,
    input  axi_rdata, axi_rresp, axi_rvalid, output axi_rready,
    output axi_awaddr, axi_awvalid, input axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid, input axi_wready,
    input  axi_bresp, axi_bvalid, output axi_bready
  );

  modport slave (
    input  axi_araddr, axi_arvalid, output axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid, input axi_rready,
    input  axi_awaddr, axi_awvalid, output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid, output axi_wready,
    output axi_bresp, axi_bvalid, input axi_bready
  );
endinterface

// File: rtl/gfx_fader.sv
// Frame-buffer fade engine: per pass, read each pixel, decay its intensity, write it back.
// Latency: one pixel in flight; AR, R, AW/W, B strictly serialised, then one NEXT cycle.
// Backpressure: every valid held until its ready; enable=0 pauses between pixels.
// Optional: define GFX_FADER_SKIP_EN to skip the write-back of all-zero pixels.
module gfx_fader #(
  parameter int PIXEL_BITS     = 12,
  parameter int META_BITS      = 4,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int FB_PIXELS      = 307200,
  parameter int FADE_STEP      = 1
) (
  input  logic axi_clk,
  input  logic axi_resetn,
  input  logic start,
  input  logic enable,
  output logic busy,
  output logic done,
  gfx_fader_if.master axi
);

  localparam int PM = PIXEL_BITS + META_BITS;
  localparam logic [AXI_ADDR_WIDTH-1:0] LAST_ADDR = AXI_ADDR_WIDTH'(FB_PIXELS - 1);
  localparam logic [META_BITS-1:0]      STEP      = META_BITS'(FADE_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B,
    S_NEXT
  } state_t;

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic                      arvalid_q;
  logic                      rready_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;

  logic [META_BITS-1:0]      in_meta;
  logic [META_BITS-1:0]      new_meta;
  logic [PIXEL_BITS-1:0]     in_colour;
  logic [AXI_DATA_WIDTH-1:0] faded;
  logic                      aw_fin;
  logic                      w_fin;
`ifdef GFX_FADER_SKIP_EN
  logic                      pix_zero;
`endif

  // Response codes and any pad bits above the pixel carry nothing we act on.
  logic unused_ok;
  assign unused_ok = ^{axi.axi_rresp, axi.axi_bresp, axi.axi_rdata};

  // Decay the pixel on the read data bus; colour is blanked once intensity hits zero.
  always_comb begin
    in_meta   = axi.axi_rdata[META_BITS-1:0];
    in_colour = axi.axi_rdata[PM-1:META_BITS];
    new_meta  = (in_meta > STEP) ? (in_meta - STEP) : '0;
    faded     = '0;
    faded[META_BITS-1:0] = new_meta;
    faded[PM-1:META_BITS] = (new_meta == '0) ? '0 : in_colour;
`ifdef GFX_FADER_SKIP_EN
    pix_zero  = (axi.axi_rdata[PM-1:0] == '0);
`endif
  end

  // A write channel is finished once its valid is low or is handshaking this cycle.
  assign aw_fin = !awvalid_q || axi.axi_awready;
  assign w_fin  = !wvalid_q  || axi.axi_wready;

  // Pass sequencer: walks addresses 0..FB_PIXELS-1, one read-modify-write at a time.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state     <= S_IDLE;
      addr      <= '0;
      wdata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            arvalid_q <= enable;
            state     <= S_AR;
          end
        end
        S_AR: begin
          // A pass started while paused raises arvalid only once enable returns.
          if (!arvalid_q) begin
            if (enable) arvalid_q <= 1'b1;
          end else if (axi.axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= S_R;
          end
        end
        S_R: begin
          if (axi.axi_rvalid) begin
            rready_q <= 1'b0;
            wdata_q  <= faded;
`ifdef GFX_FADER_SKIP_EN
            if (pix_zero) begin
              state <= S_NEXT;
            end else begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= S_AW_W;
            end
`else
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state     <= S_AW_W;
`endif
          end
        end
        S_AW_W: begin
          if (axi.axi_awready) awvalid_q <= 1'b0;
          if (axi.axi_wready)  wvalid_q  <= 1'b0;
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state    <= S_B;
          end
        end
        S_B: begin
          if (axi.axi_bvalid) begin
            bready_q <= 1'b0;
            state    <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (addr == LAST_ADDR) begin
            addr  <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (enable) begin
            addr      <= addr + 1'b1;
            arvalid_q <= 1'b1;
            state     <= S_AR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The write goes back to the address the pixel was read from.
  assign axi.axi_araddr  = addr;
  assign axi.axi_arvalid = arvalid_q;
  assign axi.axi_rready  = rready_q;
  assign axi.axi_awaddr  = addr;
  assign axi.axi_awvalid = awvalid_q;
  assign axi.axi_wdata   = wdata_q;
  assign axi.axi_wstrb   = '1;
  assign axi.axi_wvalid  = wvalid_q;
  assign axi.axi_bready  = bready_q;

endmodule
